// File: rtl/palindrome_nb.sv
`default_nettype none
// ============================================================================
// Module   : palindrome_nb
// Function : Serial-stream palindrome detector, run-time window length 2..N,
//            with valid qualifier, synchronous clear and saturating hit count.
// Revision : 1.0 - initial release
// ============================================================================
module palindrome_nb #(
    parameter  int N     = 8,
    parameter  int CNT_W = 8,
    localparam int LEN_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             valid_i,
    input  logic             x_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             palindrome_o,
    output logic [CNT_W-1:0] hit_cnt_o,
    output logic [LEN_W-1:0] fill_o
);

    localparam int               c_num_len  = 2 ** LEN_W;
    localparam logic [LEN_W-1:0] c_fill_max = LEN_W'(N - 1);
    localparam logic [LEN_W-1:0] c_len_one  = LEN_W'(1);
    localparam logic [LEN_W-1:0] c_len_min  = LEN_W'(2);
    localparam logic [LEN_W-1:0] c_len_max  = LEN_W'(N);

    logic [N-2:0]       r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [CNT_W-1:0]   r_hit_cnt;

    logic [N-1:0]       w_win;
    logic [N-2:0]       w_hist_nxt;
    logic [c_num_len-1:0] w_sym;
    logic               w_len_ok;
    logic               w_filled;
    logic               w_hit;

    // Window bit 0 is the live input; older bits come from history.
    assign w_win = {r_hist, x_i};

    generate
        if (N == 2) begin : g_shift_one
            assign w_hist_nxt = x_i;
        end else begin : g_shift_many
            assign w_hist_nxt = {r_hist[N-3:0], x_i};
        end
    endgenerate

    // One symmetry result per encodable length; unusable lengths read as 0.
    generate
        for (genvar L = 0; L < c_num_len; L++) begin : g_len
            if (L < 2 || L > N) begin : g_invalid
                assign w_sym[L] = 1'b0;
            end else begin : g_cmp
                logic [L/2-1:0] w_eq;
                for (genvar k = 0; k < L / 2; k++) begin : g_pair
                    assign w_eq[k] = (w_win[k] == w_win[L-1-k]);
                end
                assign w_sym[L] = &w_eq;
            end
        end
    endgenerate

    assign w_len_ok = (len_i >= c_len_min) && (len_i <= c_len_max);
    // Subtraction only matters when len_i is in range, so it cannot underflow.
    assign w_filled = (r_fill >= (len_i - c_len_one));
    assign w_hit    = valid_i && !clear_i && w_len_ok && w_filled && w_sym[len_i];

    assign palindrome_o = w_hit;
    assign hit_cnt_o    = r_hit_cnt;
    assign fill_o       = r_fill;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist    <= '0;
            r_fill    <= '0;
            r_hit_cnt <= '0;
        end else if (clear_i) begin
            r_hist    <= '0;
            r_fill    <= '0;
            r_hit_cnt <= '0;
        end else begin
            if (valid_i) begin
                r_hist <= w_hist_nxt;
                if (r_fill != c_fill_max) begin
                    r_fill <= r_fill + c_len_one;
                end
            end
            if (w_hit && (r_hit_cnt != {CNT_W{1'b1}})) begin
                r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_palindrome_nb.sv
`default_nettype none
// ============================================================================
// Module   : tb_palindrome_nb
// Function : Directed self-checking bench for palindrome_nb.
// Revision : 1.0 - initial release
// ============================================================================
module tb_palindrome_nb;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear_i;
    logic       valid_i;
    logic       x_i;
    logic [3:0] len_i;
    logic       pal;
    logic       pal_sat;
    logic [7:0] hit_cnt;
    logic [1:0] hit_sat;
    logic [3:0] fill;
    logic [3:0] fill_sat;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    palindrome_nb #(.N(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .clear_i(clear_i), .valid_i(valid_i),
        .x_i(x_i), .len_i(len_i), .palindrome_o(pal), .hit_cnt_o(hit_cnt),
        .fill_o(fill)
    );

    palindrome_nb #(.N(8), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .clear_i(clear_i), .valid_i(valid_i),
        .x_i(x_i), .len_i(len_i), .palindrome_o(pal_sat), .hit_cnt_o(hit_sat),
        .fill_o(fill_sat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check the combinational flag before the edge.
    task automatic step(input string tag, input logic c, input logic v, input logic x,
                        input logic [3:0] len, input logic exp_pal);
        clear_i = c;
        valid_i = v;
        x_i     = x;
        len_i   = len;
        #1;
        chk(tag, 32'(pal), 32'(exp_pal));
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        valid_i = 1'b0;
    endtask

    task automatic do_clear();
        step("clear_pal", 1'b1, 1'b0, 1'b0, 4'd2, 1'b0);
        chk("clear_fill", 32'(fill), 32'd0);
        chk("clear_cnt", 32'(hit_cnt), 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        clear_i = 1'b0;
        valid_i = 1'b0;
        x_i     = 1'b0;
        len_i   = 4'd3;
        #1;
        chk("rst_cnt", 32'(hit_cnt), 32'd0);
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_pal", 32'(pal), 32'd0);
        #12;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Length 3 from power-up
        step("l3_b0", 1'b0, 1'b1, 1'b1, 4'd3, 1'b0);
        step("l3_b1", 1'b0, 1'b1, 1'b0, 4'd3, 1'b0);
        step("l3_b2", 1'b0, 1'b1, 1'b1, 4'd3, 1'b1);
        chk("l3_cnt", 32'(hit_cnt), 32'd1);
        chk("l3_fill", 32'(fill), 32'd3);

        // Length 5 with a gap after every bit
        do_clear();
        step("l5_b0", 1'b0, 1'b1, 1'b1, 4'd5, 1'b0);
        step("l5_g0", 1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
        step("l5_b1", 1'b0, 1'b1, 1'b1, 4'd5, 1'b0);
        step("l5_g1", 1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
        step("l5_b2", 1'b0, 1'b1, 1'b0, 4'd5, 1'b0);
        step("l5_g2", 1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
        step("l5_b3", 1'b0, 1'b1, 1'b1, 4'd5, 1'b0);
        step("l5_g3", 1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
        step("l5_b4", 1'b0, 1'b1, 1'b1, 4'd5, 1'b1);
        step("l5_g4", 1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
        chk("l5_cnt", 32'(hit_cnt), 32'd1);
        chk("l5_fill", 32'(fill), 32'd5);

        // Run-time length change, out-of-range lengths, fill saturation
        do_clear();
        step("rl_b0", 1'b0, 1'b1, 1'b0, 4'd4, 1'b0);
        step("rl_b1", 1'b0, 1'b1, 1'b1, 4'd4, 1'b0);
        step("rl_b2", 1'b0, 1'b1, 1'b1, 4'd4, 1'b0);
        step("rl_b3", 1'b0, 1'b1, 1'b0, 4'd4, 1'b1);
        step("rl_len2", 1'b0, 1'b1, 1'b0, 4'd2, 1'b1);
        step("rl_len9", 1'b0, 1'b1, 1'b0, 4'd9, 1'b0);
        chk("rl_cnt", 32'(hit_cnt), 32'd2);
        step("rl_len1", 1'b0, 1'b1, 1'b0, 4'd1, 1'b0);
        step("rl_len0", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("rl_cnt2", 32'(hit_cnt), 32'd2);
        chk("rl_fill_sat", 32'(fill), 32'd7);

        // Clear has priority over valid
        do_clear();
        step("cp_b0", 1'b0, 1'b1, 1'b1, 4'd8, 1'b0);
        step("cp_b1", 1'b0, 1'b1, 1'b0, 4'd8, 1'b0);
        step("cp_b2", 1'b0, 1'b1, 1'b1, 4'd8, 1'b0);
        step("cp_b3", 1'b0, 1'b1, 1'b1, 4'd8, 1'b0);
        step("cp_b4", 1'b0, 1'b1, 1'b0, 4'd8, 1'b0);
        step("cp_b5", 1'b0, 1'b1, 1'b1, 4'd8, 1'b0);
        step("cp_b6", 1'b0, 1'b1, 1'b0, 4'd8, 1'b0);
        chk("cp_fill7", 32'(fill), 32'd7);
        step("cp_clr_valid", 1'b1, 1'b1, 1'b0, 4'd2, 1'b0);
        chk("cp_fill0", 32'(fill), 32'd0);
        chk("cp_cnt0", 32'(hit_cnt), 32'd0);
        step("cp_post0", 1'b0, 1'b1, 1'b0, 4'd2, 1'b0);
        step("cp_post1", 1'b0, 1'b1, 1'b0, 4'd2, 1'b1);
        chk("cp_cnt1", 32'(hit_cnt), 32'd1);

        // Counter saturation on the 2-bit instance
        do_clear();
        chk("sat_cnt0", 32'(hit_sat), 32'd0);
        step("sat_b0", 1'b0, 1'b1, 1'b1, 4'd2, 1'b0);
        chk("sat_c0", 32'(hit_sat), 32'd0);
        step("sat_b1", 1'b0, 1'b1, 1'b1, 4'd2, 1'b1);
        chk("sat_c1", 32'(hit_sat), 32'd1);
        step("sat_b2", 1'b0, 1'b1, 1'b1, 4'd2, 1'b1);
        chk("sat_c2", 32'(hit_sat), 32'd2);
        step("sat_b3", 1'b0, 1'b1, 1'b1, 4'd2, 1'b1);
        chk("sat_c3", 32'(hit_sat), 32'd3);
        step("sat_b4", 1'b0, 1'b1, 1'b1, 4'd2, 1'b1);
        chk("sat_c4", 32'(hit_sat), 32'd3);
        step("sat_b5", 1'b0, 1'b1, 1'b1, 4'd2, 1'b1);
        step("sat_b6", 1'b0, 1'b1, 1'b1, 4'd2, 1'b1);
        step("sat_b7", 1'b0, 1'b1, 1'b1, 4'd2, 1'b1);
        chk("sat_hold", 32'(hit_sat), 32'd3);
        chk("sat_main", 32'(hit_cnt), 32'd7);

        // Asynchronous reset mid-stream
        do_clear();
        step("ar_b0", 1'b0, 1'b1, 1'b1, 4'd3, 1'b0);
        step("ar_b1", 1'b0, 1'b1, 1'b0, 4'd3, 1'b0);
        step("ar_b2", 1'b0, 1'b1, 1'b1, 4'd3, 1'b1);
        step("ar_b3", 1'b0, 1'b1, 1'b0, 4'd3, 1'b1);
        step("ar_b4", 1'b0, 1'b1, 1'b1, 4'd3, 1'b1);
        chk("ar_cnt_pre", 32'(hit_cnt), 32'd3);
        chk("ar_fill_pre", 32'(fill), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_cnt_now", 32'(hit_cnt), 32'd0);
        chk("ar_fill_now", 32'(fill), 32'd0);
        @(posedge clk);
        #4;
        reset = 1'b0;
        @(posedge clk);
        #1;
        step("ar_p0", 1'b0, 1'b1, 1'b1, 4'd3, 1'b0);
        step("ar_p1", 1'b0, 1'b1, 1'b1, 4'd3, 1'b0);
        step("ar_p2", 1'b0, 1'b1, 1'b1, 4'd3, 1'b1);
        chk("ar_cnt_post", 32'(hit_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/palindrome_nb.md
# palindrome_nb

Serial-stream palindrome detector with a run-time programmable window length. It generalises the fixed 3-bit detector to any window length from 2 to N bits, adds a valid qualifier, a synchronous clear and a saturating hit counter. It sits on a 1-bit serial data path and flags every accepted bit that completes a palindrome over the most recent len_i bits.

## Interface
- N, 8: maximum window length in bits; legal range N ≥ 2.
- CNT_W, 8: width of the hit counter.
- LEN_W, $clog2(N+1): width of len_i; derived, not overridden.

- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- clear_i  input  1  synchronous clear of history, fill and counter.
- valid_i  input  1  x_i is a valid stream bit this cycle.
- x_i  input  1  serial data bit.
- len_i  input  LEN_W  window length; legal 2..N.
- palindrome_o  output  1  combinational; the current window is a palindrome.
- hit_cnt_o  output  CNT_W  registered, saturating count of palindrome_o pulses.
- fill_o  output  LEN_W  registered count of stored history bits, saturating at N-1.

## Operation
- History register hist[N-2:0] holds the previously accepted bits; hist[0] is the most recent.
- On a clock edge with valid_i=1 and clear_i=0: hist shifts up by one, hist[0] ← x_i, and fill increments, saturating at N-1.
- With valid_i=0, hist and fill hold and palindrome_o=0.
- Window w[0..len_i-1] is defined as w[0]=x_i and w[k]=hist[k-1] for k ≥ 1.
- palindrome_o=1 only when all of the following hold:
  - valid_i=1
  - clear_i=0
  - 2 ≤ len_i ≤ N
  - fill ≥ len_i-1
  - w[k]==w[len_i-1-k] for every k < len_i/2 (integer division; the middle bit of an odd window is ignored).
- If len_i is out of range (0, 1 or >N), palindrome_o=0 and hit_cnt_o does not increment. History and fill still update normally.
- len_i is sampled combinationally every cycle and may change at any time. The new length applies in the same cycle against the existing history. Fill is not reset.
- hit_cnt_o increments at the clock edge where palindrome_o=1, saturating at 2^CNT_W-1 with no wrap.
- clear_i=1 at a clock edge: hist←0, fill←0, hit_cnt_o←0.
  - clear_i has priority over valid_i; the bit presented that cycle is discarded.
  - palindrome_o is forced to 0 while clear_i=1.

## Timing
- Reset values: hist=0, fill_o=0, hit_cnt_o=0, palindrome_o=0 (the fill gate holds it low). Reset takes effect immediately, independent of clk.
- palindrome_o has zero-cycle latency: it is combinational from x_i, valid_i, len_i, clear_i and the registered state.
- hit_cnt_o and fill_o update one cycle after the qualifying input, on the same edge that shifts x_i into hist.
- Dead zone: after reset or clear, the first len_i-1 accepted bits cannot produce a hit. The bit at accepted index len_i-1 (zero-based) is the first one that can.
- Gaps (valid_i=0) of any length are transparent to detection; the window consists of accepted bits only.
- Reset asserted mid-stream discards all history. Behaviour after release is identical to power-up.
- Simultaneous clear_i and valid_i: clear wins, no hit is counted, fill_o=0 next cycle.

## Test plan
- **Length 3, power-up:** N=8, len_i=3, bits 1,0,1 on consecutive valid cycles.
  - palindrome_o=0 on the first two bits, 1 on the third.
  - hit_cnt_o=1 afterwards, fill_o=3.
- **Length 5 with gaps:** len_i=5, bits 1,1,0,1,1 with valid_i=0 inserted between every bit.
  - palindrome_o=1 only on the fifth accepted bit.
  - palindrome_o=0 during every gap cycle.
  - hit_cnt_o=1.
- **Run-time length change:** send 0,1,1,0 with len_i=4; hit expected on the fourth bit.
  - Then switch to len_i=2 and send 0; hit expected, since hist[0]=0.
  - Then switch to len_i=9 and send 0; palindrome_o=0 (out of range).
  - hit_cnt_o=2.
- **Clear priority:** after 7 accepted bits, assert clear_i together with valid_i.
  - Next cycle: fill_o=0, hit_cnt_o=0.
  - With len_i=2, the first post-clear bit gives palindrome_o=0 even if it matches the old history.
- **Saturation:** CNT_W=2, len_i=2, stream of 8 consecutive 1s.
  - palindrome_o=1 from the second bit onward.
  - hit_cnt_o steps 1, 2, 3 and then holds at 3.
- **Async reset mid-stream:** assert reset between clock edges after 5 bits.
  - hit_cnt_o and fill_o go to 0 immediately.
  - After release with len_i=3, bits 1,1,1 hit only on the third bit.
